// File: rtl/rijndael_sbox_arbiter_if.sv
// rijndael_sbox_arbiter_if: request bus and result bus of the shared S-box.
// Ports: req/din/key/gnt (requesters), busy, out_valid/out_ready/dout/out_id.
interface rijndael_sbox_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]      req;
  logic [N_REQ-1:0][7:0] din;
  logic [N_REQ-1:0][7:0] key;
  logic [N_REQ-1:0]      gnt;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            dout;
  logic [ID_W-1:0]       out_id;

  modport slave (
    input  req, din, key, out_ready,
    output gnt, busy, out_valid, dout, out_id
  );

  modport master (
    output req, din, key, out_ready,
    input  gnt, busy, out_valid, dout, out_id
  );
endinterface

// File: rtl/rijndael_sbox_arbiter.sv
// rijndael_sbox_arbiter: N requesters share one AES S-box; result = S(din^key).
// Ports: i_clk, i_rst (sync, active-high), bus (slave). Macro: ROUND_ROBIN_EN.
module rijndael_sbox_lut (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  localparam logic [0:255][7:0] LUT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_s = LUT[i_a];
endmodule

module rijndael_sbox_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic                      i_clk,
  input logic                      i_rst,
  rijndael_sbox_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_OUT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_data;
  logic [ID_W-1:0]  r_id;
  logic [7:0]       w_sbox;
  logic             w_hit;
  logic [ID_W-1:0]  w_win;
  logic [N_REQ-1:0] w_gnt;
  logic             w_take;

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0] r_ptr;

  // Walk from the farthest offset down so the
  // nearest requester at/after r_ptr wins.
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[(int'(r_ptr) + i) % N_REQ]) begin
        w_hit = 1'b1;
        w_win = ID_W'((int'(r_ptr) + i) % N_REQ);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= (w_win == ID_W'(N_REQ - 1)) ?
               '0 : w_win + 1'b1;
    end
  end
`else
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_hit = 1'b1;
        w_win = ID_W'(i);
      end
    end
  end
`endif

  assign w_take = (r_state == S_IDLE) && w_hit;

  always_comb begin
    w_gnt = '0;
    if (w_take) begin
      w_gnt[w_win] = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_hit) w_next = S_SUB;
      S_SUB:  w_next = S_OUT;
      S_OUT:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_data  <= 8'h00;
      r_id    <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_data <= bus.din[w_win] ^ bus.key[w_win];
        r_id   <= w_win;
      end else if (r_state == S_SUB) begin
        r_data <= w_sbox;
      end
    end
  end

  rijndael_sbox_lut u_sbox (
    .i_a (r_data),
    .o_s (w_sbox)
  );

  assign bus.gnt       = w_gnt;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.dout      = r_data;
  assign bus.out_id    = r_id;
endmodule

// File: tb/tb_rijndael_sbox_arbiter.sv
// tb_rijndael_sbox_arbiter: directed vectors with a result scoreboard.
// Runs for either build of ROUND_ROBIN_EN.
module tb_rijndael_sbox_arbiter;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rijndael_sbox_arbiter_if #(.N_REQ(4)) bus ();

  rijndael_sbox_arbiter #(.N_REQ(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [9:0] sb[$];
  logic [9:0] mon_e;
  logic [7:0] exp_tab [4] = '{8'h63, 8'h7c, 8'h77, 8'h7b};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: gnt legality each cycle, result pops on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
      if (bus.busy) chk("gnt_busy", 32'(bus.gnt), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(bus.out_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("dout", 32'(bus.dout), 32'(mon_e[7:0]));
          chk("out_id", 32'(bus.out_id), 32'(mon_e[9:8]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [3:0] g, output int at);
    bit got;
    got = 1'b0;
    g = '0;
    at = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.gnt != 0) begin
        got = 1'b1;
        g = bus.gnt;
        at = cyc;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got none expected grant");
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy stuck high");
    end
  endtask

  task automatic single(input int idx, input logic [7:0] d,
                        input logic [7:0] k, input logic [7:0] e);
    step();
    bus.din[idx] = d;
    bus.key[idx] = k;
    bus.out_ready = 1'b1;
    bus.req = 4'(1 << idx);
    sb.push_back({2'(idx), e});
    @(negedge clk);
    chk("single_gnt", 32'(bus.gnt), 32'(1 << idx));
    chk("single_c0_busy", 32'(bus.busy), 32'd0);
    step();
    bus.req = '0;
    @(negedge clk);
    chk("single_c1_valid", 32'(bus.out_valid), 32'd0);
    chk("single_c1_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("single_c2_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("single_c3_idle", 32'(bus.busy), 32'd0);
  endtask

  logic [3:0] g;
  int at, prev, ei;

  initial begin
    bus.req = '0;
    bus.din = '0;
    bus.key = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_id", 32'(bus.out_id), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);

    single(0, 8'h00, 8'h00, 8'h63);
    single(2, 8'h53, 8'h00, 8'hed);

    // Reset clears the pointer before the sweep.
    step(); rst = 1'b1;
    step(); rst = 1'b0;

    step();
    bus.din = {8'h03, 8'h02, 8'h01, 8'h00};
    bus.key = '0;
    bus.req = 4'hf;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, at);
      ei = RR ? (k % 4) : 0;
      chk("sweep_gnt", 32'(g), 32'(1 << ei));
      sb.push_back({2'(ei), exp_tab[ei]});
      if (k > 0) chk("sweep_space", 32'(at - prev), 32'd3);
      prev = at;
    end
    step();
    bus.req = '0;
    wait_idle();

    // Backpressure with a waiting requester.
    step();
    bus.out_ready = 1'b0;
    bus.din[1] = 8'h10;
    bus.key[1] = 8'h01;
    bus.req = 4'b0010;
    sb.push_back({2'd1, 8'h82});
    wait_grant(g, at);
    chk("bp_gnt", 32'(g), 32'h2);
    step();
    bus.req = 4'b0001;
    bus.din[0] = 8'hff;
    bus.key[0] = 8'h00;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_dout", 32'(bus.dout), 32'h82);
      chk("bp_id", 32'(bus.out_id), 32'd1);
      chk("bp_gnt0", 32'(bus.gnt), 32'd0);
    end
    sb.push_back({2'd0, 8'h16});
    step();
    bus.out_ready = 1'b1;
    wait_grant(g, at);
    chk("bp_next_gnt", 32'(g), 32'h1);
    step();
    bus.req = '0;
    wait_idle();

    // Reset during SUB aborts the result.
    step();
    bus.din[2] = 8'h00;
    bus.key[2] = 8'h01;
    bus.req = 4'b0100;
    wait_grant(g, at);
    chk("abort_gnt", 32'(g), 32'h4);
    step();
    bus.req = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_sub_busy", 32'(bus.busy), 32'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
    end

    // Pointer back at 0: 1100 must pick 2.
    step();
    bus.req = 4'b1100;
    sb.push_back({2'd2, 8'h7c});
    wait_grant(g, at);
    chk("ptr_rst_gnt", 32'(g), 32'h4);
    step();
    bus.req = '0;
    wait_idle();

    // Pointer at 3 with 1001: 3 then wrap to 0.
    step();
    bus.din[3] = 8'hff;
    bus.key[3] = 8'h0f;
    bus.din[0] = 8'h9a;
    bus.key[0] = 8'h00;
    bus.req = 4'b1001;
    wait_grant(g, at);
    ei = RR ? 3 : 0;
    chk("wrap_gnt1", 32'(g), 32'(1 << ei));
    sb.push_back({2'(ei), RR ? 8'h8c : 8'hb8});
    wait_grant(g, at);
    chk("wrap_gnt2", 32'(g), 32'h1);
    sb.push_back({2'd0, 8'hb8});
    step();
    bus.req = '0;
    wait_idle();

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
